// File: rtl/cv32e40p_tmr_pkg.sv
// Shared types and helpers for the TMR voter: replica count, health-state encoding
// and the per-bit majority function.
package cv32e40p_tmr_pkg;

  localparam int unsigned NUM_REP = 3;

  typedef enum logic [1:0] {
    REP_HEALTHY,
    REP_SUSPECT,
    REP_FAULTY
  } rep_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/cv32e40p_tmr_rep_monitor.sv
// Health tracker for one replica: HEALTHY/SUSPECT/FAULTY state machine, consecutive
// mismatch run counter and a saturating lifetime mismatch counter.
module cv32e40p_tmr_rep_monitor
  import cv32e40p_tmr_pkg::*;
#(
  parameter int unsigned THRESH = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             update_i,
  input  logic             mismatch_i,
  output logic             faulty_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int unsigned RUN_W = $clog2(THRESH + 1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(THRESH - 1);

  rep_state_e       state_q;
  logic [RUN_W-1:0] run_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= REP_HEALTHY;
      run_q   <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      state_q <= REP_HEALTHY;
      run_q   <= '0;
      cnt_q   <= '0;
    end else if (update_i) begin
      if (mismatch_i && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      unique case (state_q)
        REP_HEALTHY: begin
          if (mismatch_i) begin
            state_q <= (THRESH == 1) ? REP_FAULTY : REP_SUSPECT;
            run_q   <= RUN_ONE;
          end
        end
        REP_SUSPECT: begin
          if (mismatch_i) begin
            // run_q counts mismatches seen so far; this one completes the run
            if (run_q == RUN_LAST) begin
              state_q <= REP_FAULTY;
            end
            run_q <= run_q + 1'b1;
          end else begin
            state_q <= REP_HEALTHY;
            run_q   <= '0;
          end
        end
        REP_FAULTY: begin
          state_q <= REP_FAULTY;
        end
        default: begin
          state_q <= REP_HEALTHY;
          run_q   <= '0;
        end
      endcase
    end
  end

  assign faulty_o  = (state_q == REP_FAULTY);
  assign err_cnt_o = cnt_q;

endmodule

// File: rtl/cv32e40p_tmr_voter.sv
// Triple-modular-redundancy voter with per-replica health monitoring and degraded
// two-replica compare mode. Optional fault injection: CV32E40P_TMR_FAULT_INJ_EN.
module cv32e40p_tmr_voter
  import cv32e40p_tmr_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned THRESH = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_i,
  input  logic [WIDTH-1:0]         rep0_i,
  input  logic [WIDTH-1:0]         rep1_i,
  input  logic [WIDTH-1:0]         rep2_i,
  input  logic                     clear_i,
`ifdef CV32E40P_TMR_FAULT_INJ_EN
  input  logic [1:0]               inj_sel_i,
  input  logic [WIDTH-1:0]         inj_mask_i,
`endif
  output logic                     valid_o,
  output logic [WIDTH-1:0]         voted_o,
  output logic [NUM_REP-1:0]       mismatch_o,
  output logic [NUM_REP-1:0]       fault_o,
  output logic                     uncorrectable_o,
  output logic [NUM_REP*CNT_W-1:0] err_cnt_o
);

  logic [WIDTH-1:0]   rep [NUM_REP];
  logic [WIDTH-1:0]   maj;
  logic [WIDTH-1:0]   voted;
  logic [NUM_REP-1:0] mismatch;
  logic [NUM_REP-1:0] faulty;
  logic               unc_set;

  logic               valid_q;
  logic [WIDTH-1:0]   voted_q;
  logic [NUM_REP-1:0] mismatch_q;
  logic               unc_q;

`ifdef CV32E40P_TMR_FAULT_INJ_EN
  always_comb begin
    rep[0] = rep0_i ^ ((inj_sel_i == 2'd0) ? inj_mask_i : '0);
    rep[1] = rep1_i ^ ((inj_sel_i == 2'd1) ? inj_mask_i : '0);
    rep[2] = rep2_i ^ ((inj_sel_i == 2'd2) ? inj_mask_i : '0);
  end
`else
  always_comb begin
    rep[0] = rep0_i;
    rep[1] = rep1_i;
    rep[2] = rep2_i;
  end
`endif

  always_comb begin
    maj = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      maj[b] = maj3(rep[0][b], rep[1][b], rep[2][b]);
    end
  end

  // Faulty flags are the registered state, so a newly condemned replica is
  // excluded only from the following valid sample onward.
  always_comb begin
    voted   = rep[2];
    unc_set = 1'b0;
    if (faulty == 3'b000) begin
      voted = maj;
    end else if (!faulty[0]) begin
      voted = rep[0];
    end else if (!faulty[1]) begin
      voted = rep[1];
    end

    mismatch = '0;
    for (int unsigned i = 0; i < NUM_REP; i++) begin
      mismatch[i] = (rep[i] != voted);
    end

    unique case (faulty)
      3'b000: unc_set = 1'b0;
      3'b001: if (rep[1] != rep[2]) begin
        mismatch[1] = 1'b1;
        mismatch[2] = 1'b1;
        unc_set     = 1'b1;
      end
      3'b010: if (rep[0] != rep[2]) begin
        mismatch[0] = 1'b1;
        mismatch[2] = 1'b1;
        unc_set     = 1'b1;
      end
      3'b100: if (rep[0] != rep[1]) begin
        mismatch[0] = 1'b1;
        mismatch[1] = 1'b1;
        unc_set     = 1'b1;
      end
      default: unc_set = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      voted_q    <= '0;
      mismatch_q <= '0;
      unc_q      <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        voted_q    <= voted;
        mismatch_q <= mismatch;
      end
      if (clear_i) begin
        unc_q <= 1'b0;
      end else if (valid_i && unc_set) begin
        unc_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REP; g++) begin : g_mon
    cv32e40p_tmr_rep_monitor #(
      .THRESH (THRESH),
      .CNT_W  (CNT_W)
    ) u_mon (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear_i),
      .update_i   (valid_i),
      .mismatch_i (mismatch[g]),
      .faulty_o   (faulty[g]),
      .err_cnt_o  (err_cnt_o[g*CNT_W +: CNT_W])
    );
  end

  assign valid_o         = valid_q;
  assign voted_o         = voted_q;
  assign mismatch_o      = mismatch_q;
  assign fault_o         = faulty;
  assign uncorrectable_o = unc_q;

endmodule

// File: tb/tb_cv32e40p_tmr_voter.sv
// Scoreboard bench for cv32e40p_tmr_voter: stimulus pushes model predictions, a
// monitor pops and compares them whenever valid_o is high.
module tb_cv32e40p_tmr_voter;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned THRESH = 4;
  localparam int unsigned CNT_W  = 3;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  typedef struct {
    logic [WIDTH-1:0]   voted;
    logic [2:0]         mm;
    logic [2:0]         fault;
    logic               unc;
    logic [3*CNT_W-1:0] cnt;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_ni;
  logic               valid_i;
  logic [WIDTH-1:0]   rep0, rep1, rep2;
  logic               clear_i;
  logic [1:0]         inj_sel = 2'd3;
  logic [WIDTH-1:0]   inj_mask = '0;
  logic               valid_o;
  logic [WIDTH-1:0]   voted_o;
  logic [2:0]         mismatch_o;
  logic [2:0]         fault_o;
  logic               uncorrectable_o;
  logic [3*CNT_W-1:0] err_cnt_o;

  int checks = 0;
  int failures = 0;

  exp_t sbq[$];
  int   m_run[3];
  bit   m_faulty[3];
  int   m_cnt[3];
  bit   m_unc;

  always #5 clk = ~clk;

  cv32e40p_tmr_voter #(
    .WIDTH  (WIDTH),
    .THRESH (THRESH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .valid_i         (valid_i),
    .rep0_i          (rep0),
    .rep1_i          (rep1),
    .rep2_i          (rep2),
    .clear_i         (clear_i),
`ifdef CV32E40P_TMR_FAULT_INJ_EN
    .inj_sel_i       (inj_sel),
    .inj_mask_i      (inj_mask),
`endif
    .valid_o         (valid_o),
    .voted_o         (voted_o),
    .mismatch_o      (mismatch_o),
    .fault_o         (fault_o),
    .uncorrectable_o (uncorrectable_o),
    .err_cnt_o       (err_cnt_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0;
      m_faulty[i] = 0;
      m_cnt[i] = 0;
    end
    m_unc = 0;
  endfunction

  // Reference: majority vote by popcount, or first trusted replica once any is condemned.
  function automatic void model_step(input bit v, input bit clr);
    logic [WIDTH-1:0] e[3];
    logic [WIDTH-1:0] voted;
    logic [2:0]       mm;
    exp_t             x;
    int               nf, pick, ha, hb, ones;
    bit               unc_ev;
    e[0] = rep0 ^ ((inj_sel == 2'd0) ? inj_mask : '0);
    e[1] = rep1 ^ ((inj_sel == 2'd1) ? inj_mask : '0);
    e[2] = rep2 ^ ((inj_sel == 2'd2) ? inj_mask : '0);
    nf = 0;
    for (int i = 0; i < 3; i++) nf += int'(m_faulty[i]);
    unc_ev = 0;
    if (nf == 0) begin
      for (int b = 0; b < WIDTH; b++) begin
        ones = int'(e[0][b]) + int'(e[1][b]) + int'(e[2][b]);
        voted[b] = (ones >= 2);
      end
    end else begin
      pick = 2;
      for (int i = 2; i >= 0; i--) if (!m_faulty[i]) pick = i;
      voted = e[pick];
    end
    for (int i = 0; i < 3; i++) mm[i] = (e[i] != voted);
    if (nf == 1) begin
      ha = -1; hb = -1;
      for (int i = 0; i < 3; i++) if (!m_faulty[i]) begin
        if (ha < 0) ha = i; else hb = i;
      end
      if (e[ha] != e[hb]) begin
        mm[ha] = 1'b1;
        mm[hb] = 1'b1;
        unc_ev = 1;
      end
    end else if (nf >= 2) begin
      unc_ev = 1;
    end
    if (clr) begin
      model_reset();
    end else if (v) begin
      for (int i = 0; i < 3; i++) begin
        if (mm[i] && m_cnt[i] < CMAX) m_cnt[i]++;
        if (!m_faulty[i]) begin
          if (mm[i]) begin
            m_run[i]++;
            if (m_run[i] >= THRESH) m_faulty[i] = 1;
          end else begin
            m_run[i] = 0;
          end
        end
      end
      if (unc_ev) m_unc = 1;
    end
    if (v) begin
      x.voted = voted;
      x.mm    = mm;
      for (int i = 0; i < 3; i++) begin
        x.fault[i] = m_faulty[i];
        x.cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
      end
      x.unc = m_unc;
      sbq.push_back(x);
    end
  endfunction

  task automatic drive(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c, input bit clr);
    @(negedge clk);
    valid_i = v;
    rep0 = a;
    rep1 = b;
    rep2 = c;
    clear_i = clr;
    model_step(v, clr);
  endtask

  task automatic sample(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    drive(1, a, b, c, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, '0, '0, '0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(valid_o), 64'd0);
    chk({tag, "_voted"}, 64'(voted_o), 64'd0);
    chk({tag, "_mismatch"}, 64'(mismatch_o), 64'd0);
    chk({tag, "_fault"}, 64'(fault_o), 64'd0);
    chk({tag, "_unc"}, 64'(uncorrectable_o), 64'd0);
    chk({tag, "_errcnt"}, 64'(err_cnt_o), 64'd0);
  endtask

  task automatic random_phase(input int n);
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] r[3];
    int bad;
    bad = $urandom_range(0, 2);
    for (int k = 0; k < n; k++) begin
      if ((k % 60) == 0) bad = $urandom_range(0, 2);
      base = $urandom;
      for (int i = 0; i < 3; i++) begin
        r[i] = base;
        if ((i == bad) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0))
          r[i] = base ^ (32'h1 << $urandom_range(0, 31));
      end
`ifdef CV32E40P_TMR_FAULT_INJ_EN
      inj_sel  = 2'($urandom_range(0, 3));
      inj_mask = ($urandom_range(0, 3) == 0) ? $urandom : '0;
`endif
      drive($urandom_range(0, 3) != 0, r[0], r[1], r[2], $urandom_range(0, 29) == 0);
    end
    inj_sel  = 2'd3;
    inj_mask = '0;
  endtask

  // Monitor: pops on valid_o, otherwise checks that voted/mismatch hold.
  initial begin : monitor
    exp_t x;
    logic [WIDTH-1:0] last_v;
    logic [2:0]       last_m;
    last_v = '0;
    last_m = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_ni) begin
        last_v = '0;
        last_m = '0;
      end else if (valid_o) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid_o", 64'(valid_o), 64'd0);
        end else begin
          x = sbq.pop_front();
          chk("voted", 64'(voted_o), 64'(x.voted));
          chk("mismatch", 64'(mismatch_o), 64'(x.mm));
          chk("fault", 64'(fault_o), 64'(x.fault));
          chk("uncorrectable", 64'(uncorrectable_o), 64'(x.unc));
          chk("err_cnt", 64'(err_cnt_o), 64'(x.cnt));
          last_v = x.voted;
          last_m = x.mm;
        end
      end else begin
        chk("voted_hold", 64'(voted_o), 64'(last_v));
        chk("mismatch_hold", 64'(mismatch_o), 64'(last_m));
      end
    end
  end

  initial begin : stimulus
    rst_ni = 1'b0;
    valid_i = 1'b0;
    clear_i = 1'b0;
    rep0 = '0;
    rep1 = '0;
    rep2 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    idle(2);

    // clean samples
    repeat (3) sample(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    // single-bit error on replica 1, then recovery
    sample(32'hDEADBEEF, 32'hDEADBEEE, 32'hDEADBEEF);
    sample(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    // persistent fault on replica 2, then healthy pair disagrees
    repeat (4) sample(32'h0000_1234, 32'h0000_1234, 32'hFFFF_0000);
    sample(32'h1, 32'h2, 32'h1);
    sample(32'h5, 32'h5, 32'h7);
    // clear alone, then gapped run on replica 1
    drive(0, '0, '0, '0, 1);
    repeat (3) sample(32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5);
    idle(5);
    sample(32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5);
    sample(32'h3C, 32'h3C, 32'h3C);
    // clear together with valid
    drive(1, 32'h77, 32'h77, 32'h78, 1);
    // saturation on replica 0
    repeat (10) sample(32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h0F0F_0F0F);
    drive(1, 32'h1, 32'h2, 32'h3, 1);
    sample(32'h9, 32'h9, 32'h9);

    random_phase(250);

    // asynchronous reset with a sample in flight
    sample(32'h1111, 32'h2222, 32'h2222);
    @(negedge clk);
    valid_i = 1'b1;
    rep0 = 32'hCAFE;
    rep1 = 32'hCAFE;
    rep2 = 32'hBEEF;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    idle(1);

    random_phase(150);

`ifdef CV32E40P_TMR_FAULT_INJ_EN
    drive(0, '0, '0, '0, 1);
    inj_sel  = 2'd0;
    inj_mask = 32'h8000_0000;
    sample('0, '0, '0);
    inj_sel  = 2'd3;
    sample('0, '0, '0);
    inj_mask = '0;
`endif

    idle(4);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
